// File: rtl/linescanner_sensor_emulator_if.sv
// linescanner_sensor_emulator_if: sensor pin bundle between the capture unit (master) and the emulated sensor (slave)
interface linescanner_sensor_emulator_if;
    logic        rst_cvc;
    logic        rst_cds;
    logic        sample;
    logic        load_pulse;
    logic [1:0]  pattern_sel;
    logic [7:0]  pattern_value;
    logic        end_adc;
    logic        lval;
    logic [7:0]  data;
    logic [15:0] line_count;
    logic        protocol_error;
    modport master (
        output rst_cvc, rst_cds, sample, load_pulse, pattern_sel, pattern_value,
        input  end_adc, lval, data, line_count, protocol_error
    );
    modport slave (
        input  rst_cvc, rst_cds, sample, load_pulse, pattern_sel, pattern_value,
        output end_adc, lval, data, line_count, protocol_error
    );
endinterface

// File: rtl/linescanner_sensor_emulator.sv
// linescanner_sensor_emulator: line-scan sensor model with an ADC conversion FSM and an independent line readout FSM
module linescanner_sensor_emulator #(
    parameter int NUM_PIXELS   = 2048,
    parameter int ADC_CLOCKS   = 64,
    parameter int LOAD_TO_LVAL = 2
) (
    input logic pixel_clock,
    input logic n_reset,
    linescanner_sensor_emulator_if.slave sif
);
    localparam int AW = $clog2(ADC_CLOCKS + 1);
    localparam int DW = $clog2(LOAD_TO_LVAL + 1);
    typedef enum logic {ADC_IDLE, ADC_CONV} adc_t;
    typedef enum logic [1:0] {RD_IDLE, RD_DELAY, RD_LINE} rd_t;
    adc_t adc_state_q, adc_state_d;
    rd_t rd_state_q, rd_state_d;
    logic [AW-1:0] adc_cnt_q, adc_cnt_d;
    logic [DW-1:0] dly_cnt_q, dly_cnt_d;
    logic [11:0] pix_idx_q, pix_idx_d;
    logic sample_q, sample_d, load_q, load_d;
    logic end_adc_q, end_adc_d, lval_q, lval_d, protocol_error_q, protocol_error_d;
    logic [7:0] data_q, data_d, conv_line_q, conv_line_d, rd_line_q, rd_line_d, pat_val_q, pat_val_d;
    logic [1:0] pat_sel_q, pat_sel_d;
    logic [15:0] line_count_q, line_count_d;
    logic sample_re, load_re;
    function automatic logic [7:0] pixel(logic [7:0] i, logic [1:0] sel, logic [7:0] val, logic [7:0] l);
        return sel == 2'd0 ? i + l : sel == 2'd1 ? val : sel == 2'd2 ? {8{i[3] ^ l[0]}} : 8'h00;
    endfunction
    assign sample_re = sif.sample & ~sample_q;
    assign load_re   = sif.load_pulse & ~load_q;
    always_comb begin
        sample_d         = sif.sample;
        load_d           = sif.load_pulse;
        adc_state_d      = adc_state_q;
        rd_state_d       = rd_state_q;
        adc_cnt_d        = adc_cnt_q;
        dly_cnt_d        = dly_cnt_q;
        pix_idx_d        = pix_idx_q;
        end_adc_d        = end_adc_q;
        lval_d           = lval_q;
        data_d           = data_q;
        conv_line_d      = conv_line_q;
        rd_line_d        = rd_line_q;
        pat_sel_d        = pat_sel_q;
        pat_val_d        = pat_val_q;
        line_count_d     = line_count_q;
        protocol_error_d = protocol_error_q;
        if (adc_state_q == ADC_IDLE) begin
            if (sample_re) begin
                adc_state_d = ADC_CONV;
                adc_cnt_d   = '0;
                end_adc_d   = 1'b0;
                if (sif.rst_cvc | sif.rst_cds) protocol_error_d = 1'b1;
            end
        end else begin
            if (sample_re) protocol_error_d = 1'b1;
            if (adc_cnt_q == AW'(ADC_CLOCKS - 1)) begin
                adc_state_d  = ADC_IDLE;
                end_adc_d    = 1'b1;
                line_count_d = line_count_q + 16'd1;
                conv_line_d  = line_count_q[7:0] + 8'd1;
            end else begin
                adc_cnt_d = adc_cnt_q + AW'(1);
            end
        end
        // A load during conversion still latches the previous conv_line.
        case (rd_state_q)
            RD_IDLE: if (load_re) begin
                rd_state_d = RD_DELAY;
                rd_line_d  = conv_line_q;
                dly_cnt_d  = '0;
                if (adc_state_q == ADC_CONV) protocol_error_d = 1'b1;
            end
            RD_DELAY: begin
                if (load_re) protocol_error_d = 1'b1;
                if (dly_cnt_q == DW'(LOAD_TO_LVAL - 1)) begin
                    rd_state_d = RD_LINE;
                    pix_idx_d  = '0;
                    pat_sel_d  = sif.pattern_sel;
                    pat_val_d  = sif.pattern_value;
                    lval_d     = 1'b1;
                    data_d     = pixel(8'd0, sif.pattern_sel, sif.pattern_value, rd_line_q);
                end else begin
                    dly_cnt_d = dly_cnt_q + DW'(1);
                end
            end
            RD_LINE: begin
                if (load_re) protocol_error_d = 1'b1;
                if (pix_idx_q == 12'(NUM_PIXELS - 1)) begin
                    rd_state_d = RD_IDLE;
                    lval_d     = 1'b0;
                    data_d     = 8'h00;
                end else begin
                    pix_idx_d = pix_idx_q + 12'd1;
                    data_d    = pixel(pix_idx_q[7:0] + 8'd1, pat_sel_q, pat_val_q, rd_line_q);
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end
    always_ff @(posedge pixel_clock or negedge n_reset) begin
        if (!n_reset) begin
            adc_state_q      <= ADC_IDLE;
            rd_state_q       <= RD_IDLE;
            adc_cnt_q        <= '0;
            dly_cnt_q        <= '0;
            pix_idx_q        <= '0;
            sample_q         <= 1'b0;
            load_q           <= 1'b0;
            end_adc_q        <= 1'b1;
            lval_q           <= 1'b0;
            data_q           <= 8'h00;
            conv_line_q      <= 8'h00;
            rd_line_q        <= 8'h00;
            pat_sel_q        <= 2'd0;
            pat_val_q        <= 8'h00;
            line_count_q     <= 16'd0;
            protocol_error_q <= 1'b0;
        end else begin
            adc_state_q      <= adc_state_d;
            rd_state_q       <= rd_state_d;
            adc_cnt_q        <= adc_cnt_d;
            dly_cnt_q        <= dly_cnt_d;
            pix_idx_q        <= pix_idx_d;
            sample_q         <= sample_d;
            load_q           <= load_d;
            end_adc_q        <= end_adc_d;
            lval_q           <= lval_d;
            data_q           <= data_d;
            conv_line_q      <= conv_line_d;
            rd_line_q        <= rd_line_d;
            pat_sel_q        <= pat_sel_d;
            pat_val_q        <= pat_val_d;
            line_count_q     <= line_count_d;
            protocol_error_q <= protocol_error_d;
        end
    end
    assign sif.end_adc        = end_adc_q;
    assign sif.lval           = lval_q;
    assign sif.data           = data_q;
    assign sif.line_count     = line_count_q;
    assign sif.protocol_error = protocol_error_q;
endmodule
